// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
//   Shared types and constants for the systolic array front-end blocks.
//
//   feeder_state_e : west feeder frame state (IDLE / STREAM / DRAIN)
//   STALL_CNT_W    : width of the feeder starved-cycle counter
// -----------------------------------------------------------------------------
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_e;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/systolic_west_feeder_skew.sv
// -----------------------------------------------------------------------------
// skew_delay_line
//   Fixed-depth shift register carrying one operand lane plus its slot-valid
//   bit. The output is the input delayed by DEPTH clock cycles.
//
//   Parameters : WIDTH  operand width
//                DEPTH  number of register stages (>= 1)
//   Ports      : i_clk  clock, rising edge
//                i_rst  synchronous active-high reset, clears every stage
//                i_data / i_vld  slot entering the line
//                o_data / o_vld  slot leaving the line DEPTH cycles later
// -----------------------------------------------------------------------------
module skew_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_vld,
    output logic [WIDTH-1:0] o_data,
    output logic             o_vld
);

    logic [DEPTH-1:0][WIDTH-1:0] r_data;
    logic [DEPTH-1:0]            r_vld;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data <= '0;
            r_vld  <= '0;
        end else begin
            r_data[0] <= i_data;
            r_vld[0]  <= i_vld;
            for (int k = 1; k < DEPTH; k++) begin
                r_data[k] <= r_data[k-1];
                r_vld[k]  <= r_vld[k-1];
            end
        end
    end

    assign o_data = r_data[DEPTH-1];
    assign o_vld  = r_vld[DEPTH-1];

endmodule

// File: rtl/systolic_west_feeder.sv
// -----------------------------------------------------------------------------
// systolic_west_feeder
//   Input-skew stage in front of the systolic array west edge. Accepts one
//   ROW-wide operand vector per cycle, delays lane r by r extra cycles to form
//   the diagonal wavefront, frames each matrix as len_i vectors and drains the
//   skew pipeline (ROW cycles) before returning to IDLE.
//
//   Ports:
//     clk_i, rst_i     clock (rising) / synchronous active-high reset
//     start_i, len_i   frame start and vector count, sampled only in IDLE
//     in_valid_i       in_data_i holds a vector
//     in_ready_o       vector accepted this cycle when in_valid_i is high
//     in_data_i        [ROW-1:0][WIDTH-1:0], element r feeds lane r
//     west_o           [ROW-1:0][WIDTH-1:0], skewed operands to the array
//     west_vld_o       per-lane slot valid, skewed like west_o
//     busy_o           high in STREAM or DRAIN
//     done_o           one-cycle pulse once the frame has left lane ROW-1
//     stall_cnt_o      starved STREAM cycle counter
//
//   Handshake: a vector transfers in any cycle where in_valid_i and in_ready_o
//   are both high; in_ready_o does not depend on in_valid_i. The west side has
//   no back-pressure, so every cycle injects either the accepted vector or an
//   all-zero bubble with valid=0.
//
//   Optional build macro FEEDER_STALL_CNT_EN: when defined, stall_cnt_o counts
//   STREAM cycles with in_valid_i low (saturating, cleared by an accepted
//   start). When undefined, stall_cnt_o is tied to zero.
// -----------------------------------------------------------------------------
module systolic_west_feeder
    import systolic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ROW   = 4,
    parameter int LEN_W = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [LEN_W-1:0]            len_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [ROW-1:0][WIDTH-1:0]   in_data_i,
    output logic [ROW-1:0][WIDTH-1:0]   west_o,
    output logic [ROW-1:0]              west_vld_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [STALL_CNT_W-1:0]      stall_cnt_o
);

    localparam int                 DRAIN_W    = (ROW > 1) ? $clog2(ROW) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(ROW - 1);

    feeder_state_e      r_state;
    feeder_state_e      w_state_nxt;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic               r_done;

    logic w_fire;
    logic w_start_ok;
    logic w_last_vec;
    logic w_drain_end;

    assign w_fire      = in_valid_i & in_ready_o;
    assign w_start_ok  = (r_state == IDLE) & start_i & (len_i != '0);
    // r_cnt only reaches r_len-1 before the last handshake, so it never wraps
    // even for the largest len.
    assign w_last_vec  = (r_cnt == (r_len - LEN_W'(1)));
    assign w_drain_end = (r_state == DRAIN) & (r_drain_cnt == DRAIN_LAST);

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready_o  = 1'b0;
        busy_o      = 1'b1;
        case (r_state)
            IDLE: begin
                busy_o = 1'b0;
                if (w_start_ok) begin
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                in_ready_o = 1'b1;
                if (in_valid_i && w_last_vec) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_drain_end) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                busy_o      = 1'b0;
            end
        endcase
    end

    // ---------------- frame counters ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_len       <= '0;
            r_cnt       <= '0;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            // done is registered so it lands in the first IDLE cycle, which
            // lets a start in the same cycle be taken immediately.
            r_done <= w_drain_end;
            if (w_start_ok) begin
                r_len <= len_i;
                r_cnt <= '0;
            end else if (w_fire) begin
                r_cnt <= r_cnt + LEN_W'(1);
            end
            if (r_state == DRAIN) begin
                r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
            end else begin
                r_drain_cnt <= '0;
            end
        end
    end

    assign done_o = r_done;

    // ---------------- starved-cycle counter ----------------
`ifdef FEEDER_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (w_start_ok) begin
            r_stall_cnt <= '0;
        end else if ((r_state == STREAM) && !in_valid_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

    // ---------------- per-lane skew ----------------
    // Lane r is delayed r+1 cycles; bubbles carry zero data so the array
    // sees clean zeros between vectors.
    for (genvar r = 0; r < ROW; r++) begin : g_lane
        logic [WIDTH-1:0] w_slot;
        assign w_slot = w_fire ? in_data_i[r] : '0;

        skew_delay_line #(
            .WIDTH (WIDTH),
            .DEPTH (r + 1)
        ) u_delay (
            .i_clk  (clk_i),
            .i_rst  (rst_i),
            .i_data (w_slot),
            .i_vld  (w_fire),
            .o_data (west_o[r]),
            .o_vld  (west_vld_o[r])
        );
    end

endmodule
